// File: rtl/data_mem_hs.sv
// Data memory with valid/ready request/response handshake and configurable read latency.
// Ports: clk, rst_n, req_{valid,ready,we,size,unsigned,addr,wdata}, rsp_{valid,ready,rdata,err}.
module data_mem_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IW-1:0]         idx;
    logic [LB-1:0]         off;
    logic [2:0]            off3;
    logic [5:0]            sh;
    logic                  acc;
    logic                  err;
    logic [7:0]            sz_be;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] rsh;
    logic [63:0]           r64;
    logic                  sx;
    logic [DATA_WIDTH-1:0] ext;
    logic [DATA_WIDTH-1:0] ld;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_err;

    // Upper address bits are dropped, so addresses wrap over the array.
    assign idx  = req_addr[IW+LB-1:LB];
    assign off  = req_addr[LB-1:0];
    assign off3 = 3'(off);
    assign sh   = {off3, 3'b000};
    assign acc  = req_valid & req_ready;

    always_comb begin
        err = 1'b0;
        unique case (req_size)
            2'b00: err = 1'b0;
            2'b01: err = off3[0];
            2'b10: err = |off3[1:0];
            2'b11: err = (DATA_WIDTH != 64) | (|off3);
        endcase
    end

    always_comb begin
        sz_be = 8'h00;
        unique case (req_size)
            2'b00: sz_be = 8'h01;
            2'b01: sz_be = 8'h03;
            2'b10: sz_be = 8'h0F;
            2'b11: sz_be = 8'hFF;
        endcase
    end

    assign be = NB'(sz_be << off3);

    always_comb begin
        bmask = '0;
        for (int i = 0; i < NB; i++) begin
            bmask[8*i +: 8] = {8{be[i]}};
        end
    end

    // Sub-word store data is right-aligned; move it onto its lanes.
    assign wsh = req_wdata << sh;
    assign rsh = mem[idx] >> sh;
    assign r64 = 64'(rsh);
    assign sx  = ~req_unsigned;

    always_comb begin
        ext = '0;
        unique case (req_size)
            2'b00: ext = DATA_WIDTH'({{56{sx & r64[7]}}, r64[7:0]});
            2'b01: ext = DATA_WIDTH'({{48{sx & r64[15]}}, r64[15:0]});
            2'b10: ext = DATA_WIDTH'({{32{sx & r64[31]}}, r64[31:0]});
            2'b11: ext = DATA_WIDTH'(r64);
        endcase
    end

    assign ld = (req_we | err) ? '0 : ext;

    // RAM has no reset; a store commits on its acceptance edge.
    always_ff @(posedge clk) begin
        if (acc && req_we && !err) begin
            mem[idx] <= (mem[idx] & ~bmask) | (wsh & bmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        req_ready <= 1'b0;
                        hold_data <= ld;
                        hold_err  <= err;
                        if (RD_LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= ld;
                            rsp_err   <= err;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(RD_LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= hold_data;
                        rsp_err   <= hold_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: two instances (read latency 1 and 4) against a byte-array model.
// Directed plan steps followed by randomized traffic.
module tb_data_mem_hs;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       vld;
    logic [1:0]       rdy;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [1:0]       rv;
    logic [1:0]       rr;
    logic [1:0][31:0] rdat;
    logic [1:0]       rerr;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] rmem [2][256];

    always #5 clk = ~clk;

    data_mem_hs #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]),
        .rsp_rdata(rdat[0]), .rsp_err(rerr[0])
    );

    data_mem_hs #(.RD_LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]),
        .rsp_rdata(rdat[1]), .rsp_err(rerr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: little-endian bytes, address taken modulo 256.
    task automatic model(input int d, input bit we, input bit [1:0] sz,
                         input bit uns, input bit [31:0] a,
                         input bit [31:0] wd,
                         output bit [31:0] ed, output bit ee);
        int nb;
        int ix;
        logic [63:0] v;
        nb = 1 << sz;
        ee = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
             || (sz == 2'd3);
        ed = '0;
        if (ee) return;
        if (we) begin
            for (int i = 0; i < nb; i++) begin
                ix = (int'(a[7:0]) + i) % 256;
                rmem[d][ix] = wd[8*i +: 8];
            end
            return;
        end
        v = '0;
        for (int i = 0; i < nb; i++) begin
            ix = (int'(a[7:0]) + i) % 256;
            v = v | (64'(rmem[d][ix]) << (8 * i));
        end
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        ed = v[31:0];
    endtask

    task automatic txn(input int d, input bit we, input bit [1:0] sz,
                       input bit uns, input bit [31:0] a,
                       input bit [31:0] wd, input int hold,
                       output logic [31:0] gd, output logic ge);
        int n;
        bit [31:0] ed;
        bit ee;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", 32'(rdy[d]), 32'd1);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; vld[d] = 1'b1;
        @(posedge clk); #1;
        vld[d] = 1'b0;
        model(d, we, sz, uns, a, wd, ed, ee);
        n = 1;
        while (rv[d] !== 1'b1 && n < 40) begin
            chk("ready_low_wait", 32'(rdy[d]), 32'd0);
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), (d == 1) ? 32'd4 : 32'd1);
        gd = rdat[d];
        ge = rerr[d];
        chk("rdata", gd, ed);
        chk("err", 32'(ge), 32'(ee));
        chk("ready_low_resp", 32'(rdy[d]), 32'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rv[d]), 32'd1);
            chk("hold_rdata", rdat[d], ed);
            chk("hold_err", 32'(rerr[d]), 32'(ee));
            chk("hold_ready", 32'(rdy[d]), 32'd0);
        end
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        chk("valid_drop", 32'(rv[d]), 32'd0);
        chk("ready_back", 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] gd;
        logic ge;
        bit [31:0] ed;
        bit ee;
        int r;
        bit [1:0] sz;
        bit [31:0] a;

        rst_n = 1'b0; vld = '0; rr = '0;
        req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(rdy[d]), 32'd1);
            chk("rst_valid", 32'(rv[d]), 32'd0);
            chk("rst_rdata", rdat[d], 32'd0);
            chk("rst_err", 32'(rerr[d]), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) begin
                txn(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, gd, ge);
            end
        end

        txn(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, gd, ge);
        chk("st_word_rdata0", gd, 32'd0);
        txn(0, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 0, gd, ge);
        chk("ld_word", gd, 32'hDEADBEEF);
        txn(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h5A, 0, gd, ge);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, gd, ge);
        chk("ld_after_byte", gd, 32'hDE5ABEEF);
        txn(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, gd, ge);
        chk("ld_byte_s", gd, 32'hFFFFFFDE);
        txn(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, gd, ge);
        chk("ld_byte_u", gd, 32'h000000DE);
        txn(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, gd, ge);
        chk("ld_half_s", gd, 32'hFFFFDE5A);
        txn(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 0, gd, ge);
        chk("mis_st_err", 32'(ge), 32'd1);
        chk("mis_st_rdata", gd, 32'd0);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, gd, ge);
        chk("ld_unchanged", gd, 32'hDE5ABEEF);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, gd, ge);
        chk("mis_ld_err", 32'(ge), 32'd1);
        txn(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hA5A5A5A5, 0, gd, ge);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 0, gd, ge);
        chk("wrap", gd, 32'hA5A5A5A5);
        txn(0, 1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 0, gd, ge);
        chk("size3_err", 32'(ge), 32'd1);
        chk("size3_rdata", gd, 32'd0);

        txn(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 0, gd, ge);
        txn(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, gd, ge);
        chk("l4_ld", gd, 32'hCAFEF00D);

        // Reset in WAIT: outstanding store is dropped but already in RAM.
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h13579BDF; vld[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        model(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h13579BDF, ed, ee);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(rdy[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rv[1]), 32'd0);
        chk("mid_rst_ready", 32'(rdy[1]), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1, 1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 0, gd, ge);
        chk("rst_store_kept", gd, 32'h13579BDF);

        for (int d = 0; d < 2; d++) begin
            repeat (120) begin
                r = $urandom_range(0, 9);
                sz = (r == 9) ? 2'd3 : 2'(r % 3);
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                txn(d, 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), a, $urandom,
                    $urandom_range(0, 2), gd, ge);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
